// File: rtl/posit_encode_es3_pkg.sv
`default_nettype none
// ============================================================================
// Package  : posit_defines_es3
// Desc     : Shared Posit-32/ES=3 constants and the decoded-sum record type.
// Revision : 1.0 - initial release
// ============================================================================
package posit_defines_es3;

  localparam int NBITS     = 32;
  localparam int ES        = 3;
  localparam int FBITS     = 26;
  localparam int ABITS     = FBITS + 4;
  localparam int MAX_SCALE = (NBITS - 2) << ES;

  localparam int F_CARRY  = 29;
  localparam int F_HIDDEN = 28;
  localparam int F_GUARD  = 1;
  localparam int F_STICKY = 0;

  localparam logic [NBITS-1:0] POSIT_NAR    = 32'h8000_0000;
  localparam logic [NBITS-1:0] POSIT_MAXPOS = 32'h7FFF_FFFF;
  localparam logic [NBITS-1:0] POSIT_MINPOS = 32'h0000_0001;

  typedef struct packed {
    logic                    sign;
    logic signed [8:0]       scale;
    logic        [ABITS-1:0] fraction;
    logic                    inf;
    logic                    zero;
  } value_sum;

endpackage
`default_nettype wire

// File: rtl/posit_encode_es3_if.sv
`default_nettype none
// ============================================================================
// Interface : posit_encode_es3_if
// Desc      : Valid/ready input (decoded sum) and output (posit word) channels.
// Revision  : 1.0 - initial release
// ============================================================================
interface posit_encode_es3_if;
  import posit_defines_es3::*;

  logic             in_valid;
  logic             in_ready;
  value_sum         in_data;
  logic             out_valid;
  logic             out_ready;
  logic [NBITS-1:0] out_posit;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_posit
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_posit
  );
endinterface
`default_nettype wire

// File: rtl/posit_encode_es3_lzc.sv
`default_nettype none
// ============================================================================
// Module   : posit_lzc
// Desc     : Combinational leading-zero count; all-zero input returns W.
// Revision : 1.0 - initial release
// ============================================================================
module posit_lzc #(
  parameter int W = 29
) (
  input  wire  [W-1:0]             i_bits,
  output logic [$clog2(W+1)-1:0]   o_count
);
  localparam int c_cw = $clog2(W + 1);

  logic w_found;

  always_comb begin
    o_count = '0;
    w_found = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (i_bits[i]) begin
        w_found = 1'b1;
      end else if (!w_found) begin
        o_count = o_count + c_cw'(1);
      end
    end
  end
endmodule
`default_nettype wire

// File: rtl/posit_encode_es3.sv
`default_nettype none
// ============================================================================
// Module   : posit_encode_es3
// Desc     : 3-stage stallable Posit-32/ES=3 encoder (normalise, pack, round).
// Revision : 1.0 - initial release
// ============================================================================
module posit_encode_es3
  import posit_defines_es3::*;
(
  input  wire               clk,
  input  wire               reset_n,
  posit_encode_es3_if.slave bus
);
  localparam int                c_lz_w      = $clog2(F_HIDDEN + 2);
  localparam logic signed [9:0] c_max_scale = 10'(MAX_SCALE);
  localparam logic signed [9:0] c_min_scale = -c_max_scale;

  // Pipeline state
  logic                    r_v1, r_v2, r_v3;
  logic                    r_s1_sign, r_s1_nar, r_s1_zero;
  logic signed [9:0]       r_s1_scale;
  logic [F_HIDDEN-1:0]     r_s1_frac;
  logic                    r_s2_sign, r_s2_nar, r_s2_zero;
  logic [NBITS-2:0]        r_s2_mag;
  logic                    r_s2_round, r_s2_sticky;
  logic [NBITS-1:0]        r_posit;

  logic                    w_ld1, w_ld2, w_ld3;
  value_sum                w_in;
  logic [c_lz_w-1:0]       w_lz;
  logic [F_HIDDEN:0]       w_norm;
  logic signed [9:0]       w_scale_ext, w_s1_scale;
  logic                    w_s1_zero;

  assign w_ld3 = !r_v3 || bus.out_ready;
  assign w_ld2 = !r_v2 || w_ld3;
  assign w_ld1 = !r_v1 || w_ld2;

  assign bus.in_ready  = w_ld1;
  assign bus.out_valid = r_v3;
  assign bus.out_posit = r_posit;

  // ---------------- S1: normalise so the leading one sits at the hidden bit
  assign w_in        = bus.in_data;
  assign w_scale_ext = {w_in.scale[8], w_in.scale};

  posit_lzc #(.W(F_HIDDEN + 1)) u_lzc (
    .i_bits  (w_in.fraction[F_HIDDEN:0]),
    .o_count (w_lz)
  );

  always_comb begin
    w_norm     = '0;
    w_s1_scale = w_scale_ext;
    if (w_in.fraction[F_CARRY]) begin
      w_norm     = {w_in.fraction[F_CARRY:F_GUARD+1], |w_in.fraction[F_GUARD:F_STICKY]};
      w_s1_scale = w_scale_ext + 10'sd1;
    end else begin
      w_norm     = w_in.fraction[F_HIDDEN:0] << w_lz;
      w_s1_scale = w_scale_ext - $signed(10'(w_lz));
    end
  end

  // No leading one anywhere means the fraction was all zeros
  assign w_s1_zero = w_in.zero || !w_norm[F_HIDDEN];

  // ---------------- S2: regime/exponent/fraction string, cut at 31 bits
  logic signed [9:0]  w_k;
  logic [9:0]         w_shamt;
  logic signed [63:0] w_seed, w_str;
  logic [NBITS-2:0]   w_s2_mag;
  logic               w_s2_round, w_s2_sticky;

  assign w_k     = r_s1_scale >>> ES;
  assign w_shamt = w_k[9] ? ~w_k : w_k;
  // Seed 10 replicates into k+1 ones under the arithmetic shift; seed 01 gives -k zeros then 1
  assign w_seed  = {~w_k[9], w_k[9], r_s1_scale[ES-1:0], r_s1_frac, 31'b0};
  assign w_str   = w_seed >>> w_shamt;

  always_comb begin
    w_s2_mag    = w_str[63:33];
    w_s2_round  = w_str[32];
    w_s2_sticky = |w_str[31:0];
    if (r_s1_scale > c_max_scale) begin
      w_s2_mag    = POSIT_MAXPOS[NBITS-2:0];
      w_s2_round  = 1'b0;
      w_s2_sticky = 1'b0;
    end else if (r_s1_scale < c_min_scale) begin
      w_s2_mag    = POSIT_MINPOS[NBITS-2:0];
      w_s2_round  = 1'b0;
      w_s2_sticky = 1'b0;
    end
  end

  // ---------------- S3: round to nearest even, clamp, apply sign and specials
  logic             w_inc;
  logic [NBITS-1:0] w_mag_r, w_mag_c, w_signed, w_s3_posit;

  assign w_inc   = r_s2_round && (r_s2_sticky || r_s2_mag[0]);
  assign w_mag_r = {1'b0, r_s2_mag} + {{(NBITS-1){1'b0}}, w_inc};

  always_comb begin
    w_mag_c = w_mag_r;
    if (w_mag_r[NBITS-1]) begin
      w_mag_c = POSIT_MAXPOS;
    end else if (w_mag_r == '0) begin
      w_mag_c = POSIT_MINPOS;
    end
  end

  assign w_signed   = r_s2_sign ? (~w_mag_c + 32'd1) : w_mag_c;
  assign w_s3_posit = r_s2_nar ? POSIT_NAR : (r_s2_zero ? '0 : w_signed);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_v1        <= 1'b0;
      r_v2        <= 1'b0;
      r_v3        <= 1'b0;
      r_s1_sign   <= 1'b0;
      r_s1_nar    <= 1'b0;
      r_s1_zero   <= 1'b0;
      r_s1_scale  <= '0;
      r_s1_frac   <= '0;
      r_s2_sign   <= 1'b0;
      r_s2_nar    <= 1'b0;
      r_s2_zero   <= 1'b0;
      r_s2_mag    <= '0;
      r_s2_round  <= 1'b0;
      r_s2_sticky <= 1'b0;
      r_posit     <= '0;
    end else begin
      if (w_ld1) begin
        r_v1 <= bus.in_valid;
        if (bus.in_valid) begin
          r_s1_sign  <= w_in.sign;
          r_s1_nar   <= w_in.inf;
          r_s1_zero  <= w_s1_zero;
          r_s1_scale <= w_s1_scale;
          r_s1_frac  <= w_norm[F_HIDDEN-1:0];
        end
      end
      if (w_ld2) begin
        r_v2 <= r_v1;
        if (r_v1) begin
          r_s2_sign   <= r_s1_sign;
          r_s2_nar    <= r_s1_nar;
          r_s2_zero   <= r_s1_zero;
          r_s2_mag    <= w_s2_mag;
          r_s2_round  <= w_s2_round;
          r_s2_sticky <= w_s2_sticky;
        end
      end
      if (w_ld3) begin
        r_v3 <= r_v2;
        if (r_v2) begin
          r_posit <= w_s3_posit;
        end
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_posit_encode_es3.sv
`default_nettype none
// ============================================================================
// Module   : tb_posit_encode_es3
// Desc     : Directed and randomised checks of posit_encode_es3 against a bit-string model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_posit_encode_es3;
  import posit_defines_es3::*;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;
  int   checks  = 0;
  int   errors  = 0;

  posit_encode_es3_if bus();

  posit_encode_es3 dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic value_sum mk(input logic sgn, input int scl, input logic [29:0] fr,
                                  input logic inf, input logic zr);
    value_sum v;
    v.sign     = sgn;
    v.scale    = scl[8:0];
    v.fraction = fr;
    v.inf      = inf;
    v.zero     = zr;
    return v;
  endfunction

  function automatic value_sum rand_sum();
    int          scl;
    logic [29:0] fr;
    if ($urandom_range(0, 3) == 0) scl = int'($urandom_range(0, 511)) - 256;
    else                           scl = int'($urandom_range(0, 80)) - 40;
    fr = 30'($urandom);
    fr = fr >> $urandom_range(0, 29);
    return mk(1'($urandom), scl, fr, ($urandom_range(0, 19) == 0), ($urandom_range(0, 19) == 0));
  endfunction

  // Value = fraction * 2^(scale-28); emit the posit as a bit list and round the cut.
  function automatic logic [31:0] ref_encode(input value_sum v);
    bit          q[$];
    int          scl, p, s, k, e;
    logic [30:0] mag;
    logic [31:0] m32;
    bit          r, st;
    if (v.inf) return 32'h8000_0000;
    if (v.zero || v.fraction == 0) return 32'h0;
    scl = $signed(v.scale);
    p = 29;
    while (!v.fraction[p]) p--;
    s = scl + p - 28;
    if (s > 240) m32 = 32'h7FFF_FFFF;
    else if (s < -240) m32 = 32'h1;
    else begin
      k = (s >= 0) ? s / 8 : -((-s + 7) / 8);
      e = s - 8 * k;
      if (k >= 0) begin
        repeat (k + 1) q.push_back(1'b1);
        q.push_back(1'b0);
      end else begin
        repeat (-k) q.push_back(1'b0);
        q.push_back(1'b1);
      end
      for (int i = 2; i >= 0; i--) q.push_back(e[i]);
      for (int i = p - 1; i >= 0; i--) q.push_back(v.fraction[i]);
      mag = '0;
      for (int i = 0; i < 31; i++) mag = {mag[29:0], (i < q.size()) ? q[i] : 1'b0};
      r  = (q.size() > 31) ? q[31] : 1'b0;
      st = 1'b0;
      for (int i = 32; i < q.size(); i++) st |= q[i];
      m32 = {1'b0, mag} + ((r && (st || mag[0])) ? 32'd1 : 32'd0);
    end
    if (m32 > 32'h7FFF_FFFF) m32 = 32'h7FFF_FFFF;
    if (m32 == 0) m32 = 32'h1;
    return v.sign ? (~m32 + 32'd1) : m32;
  endfunction

  task automatic run_vec(input value_sum v, input logic [31:0] exp, input string tag,
                         output int lat);
    int n;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = v;
    @(negedge clk);
    bus.in_valid = 1'b0;
    n = 1;
    while (!bus.out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    lat = n;
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check(tag, bus.out_posit, exp);
  endtask

  value_sum    beats[8];
  logic [31:0] exps[8];

  initial begin
    int lat, acc, got, stray;
    value_sum v;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;

    #2 reset_n = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_posit", bus.out_posit, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);

    run_vec(mk(0, 0, 30'h1000_0000, 0, 0), 32'h4000_0000, "one_pos", lat);
    check("latency", lat, 3);
    run_vec(mk(1, 0, 30'h1000_0000, 0, 0), 32'hC000_0000, "one_neg", lat);
    run_vec(mk(0, 1, 30'h1000_0000, 0, 0), 32'h4400_0000, "scale1", lat);
    run_vec(mk(0, 0, 30'h2000_0000, 0, 0), 32'h4400_0000, "carry", lat);
    run_vec(mk(0, 250, 30'h1000_0000, 0, 0), 32'h7FFF_FFFF, "sat_max", lat);
    run_vec(mk(0, -250, 30'h1000_0000, 0, 0), 32'h0000_0001, "sat_min", lat);
    run_vec(mk(1, 250, 30'h1000_0000, 0, 0), 32'h8000_0001, "sat_max_neg", lat);
    run_vec(mk(1, 5, 30'h1234_5678, 0, 1), 32'h0000_0000, "zero", lat);
    run_vec(mk(1, 5, 30'h1234_5678, 1, 0), 32'h8000_0000, "inf", lat);
    run_vec(mk(0, 5, 30'h1234_5678, 1, 1), 32'h8000_0000, "inf_zero", lat);
    run_vec(mk(0, 7, 30'h0, 0, 0), 32'h0000_0000, "frac_zero", lat);
    run_vec(mk(0, 0, 30'h1FFF_FFFE, 0, 0), 32'h4400_0000, "rne_up", lat);
    run_vec(mk(0, 0, 30'h1000_0002, 0, 0), 32'h4000_0000, "rne_tie_even", lat);
    run_vec(mk(0, 0, 30'h1000_0006, 0, 0), 32'h4000_0002, "rne_tie_odd", lat);

    for (int i = 0; i < 30; i++) begin
      v = rand_sum();
      run_vec(v, ref_encode(v), $sformatf("rand%0d", i), lat);
    end

    // Stream under a 5-cycle output stall
    for (int i = 0; i < 8; i++) begin
      beats[i] = rand_sum();
      exps[i]  = ref_encode(beats[i]);
    end
    acc = 0;
    got = 0;
    for (int cyc = 0; cyc < 100 && got < 8; cyc++) begin
      @(negedge clk);
      bus.out_ready = (cyc >= 5);
      bus.in_valid  = (acc < 8);
      if (acc < 8) bus.in_data = beats[acc];
      #1;
      if (cyc == 4) begin
        check("stall_in_ready", 32'(bus.in_ready), 32'd0);
        check("stall_accepted", acc, 3);
        check("stall_hold", bus.out_posit, exps[0]);
      end
      if (bus.out_valid && bus.out_ready) begin
        check($sformatf("stream%0d", got), bus.out_posit, exps[got]);
        got++;
      end
      if (bus.in_valid && bus.in_ready) acc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    check("stream_done", got, 8);

    // Reset while beats are in flight
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = rand_sum();
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    check("pre_reset_valid", 32'(bus.out_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    check("mid_reset_valid", 32'(bus.out_valid), 32'd0);
    check("mid_reset_posit", bus.out_posit, 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    stray = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.out_valid) stray++;
    end
    check("no_stray_beat", stray, 0);
    check("post_reset_in_ready", 32'(bus.in_ready), 32'd1);
    run_vec(mk(0, 1, 30'h1000_0000, 0, 0), 32'h4400_0000, "post_reset", lat);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
